// File: rtl/pe_ctrl_pkg.sv
// Shared constants for the PE op sequencer: state encoding, mux selects,
// addsub ops and op-field bit positions.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_L2   = 2'd1,
        ST_AGGR = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_MUL  = 2'b01;
    localparam logic [1:0] SEL_ACC  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    localparam logic [1:0] ADDSUB_ADD = 2'b00;
    localparam logic [1:0] ADDSUB_SUB = 2'b01;

    localparam int OP_L2   = 0;
    localparam int OP_AGGR = 1;

endpackage

// File: rtl/pe_op_sequencer_if.sv
// Host/config handshake plus PE-facing control bus of the op sequencer.
interface pe_op_sequencer_if #(
    parameter int NUM_IP     = 8,
    parameter int NUM_ADDSUB = 2,
    parameter int CNT_W      = 8
);
    logic                      start;
    logic [1:0]                op;
    logic                      use_int_in;
    logic [2:0]                rounding_in;
    logic                      tininess_in;
    logic [CNT_W-1:0]          l2_cycles;
    logic [CNT_W-1:0]          aggr_cycles;
    logic                      abort;
    logic [31:0]               pe_out;
    logic [2*(NUM_IP+2)-1:0]   m_sel;
    logic [2*NUM_ADDSUB-1:0]   addsub_op;
    logic                      use_int;
    logic [2:0]                rounding;
    logic                      tininess;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [31:0]               result;
    logic                      result_valid;

    // host side (also stubs the PE result)
    modport master (
        output start, op, use_int_in, rounding_in, tininess_in,
               l2_cycles, aggr_cycles, abort, pe_out,
        input  m_sel, addsub_op, use_int, rounding, tininess,
               busy, done, err, result, result_valid
    );

    // sequencer side
    modport slave (
        input  start, op, use_int_in, rounding_in, tininess_in,
               l2_cycles, aggr_cycles, abort, pe_out,
        output m_sel, addsub_op, use_int, rounding, tininess,
               busy, done, err, result, result_valid
    );
endinterface

// File: rtl/pe_op_sequencer_phase_counter.sv
// Loadable down-counter; tc is high while the count is zero, i.e. on the
// last cycle of a phase that was loaded with len-1.
module pe_phase_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    // reload on phase entry, otherwise count down and park at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)          cnt <= '0;
        else if (load)       cnt <= load_val;
        else if (cnt != '0)  cnt <= cnt - CNT_W'(1);
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/pe_op_sequencer.sv
// Control FSM for the inner-product PE array: sequences L2 and AGGR phases,
// drives mux selects / addsub ops / numeric mode, and captures the PE result.
module pe_op_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_IP     = 8,
    parameter int NUM_ADDSUB = 2,
    parameter int CNT_W      = 8,
    parameter int SETTLE     = 1
) (
    input logic               clock,
    input logic               reset,
    pe_op_sequencer_if.slave  bus
);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(SETTLE - 1);

    state_e           state, state_nx;
    logic             load, tc, accept, illegal, capture;
    logic [CNT_W-1:0] load_val;
    logic             aggr_en_q;
    logic [CNT_W-1:0] aggr_q;
    logic             use_int_q, tininess_q, done_q, err_q, rv_q;
    logic [2:0]       rounding_q;
    logic [31:0]      result_q;

    pe_phase_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    // next state; the counter is reloaded on every phase entry.
    // Abort dominates start, and a zero-length or disabled phase is skipped.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        load_val = '0;
        accept   = 1'b0;
        illegal  = 1'b0;
        capture  = 1'b0;
        unique case (state)
            ST_IDLE: if (bus.start && !bus.abort) begin
                if (bus.op == 2'b00) begin
                    illegal = 1'b1;
                end else begin
                    accept = 1'b1;
                    load   = 1'b1;
                    if (bus.op[OP_L2] && bus.l2_cycles != '0) begin
                        state_nx = ST_L2;
                        load_val = bus.l2_cycles - CNT_W'(1);
                    end else if (bus.op[OP_AGGR] && bus.aggr_cycles != '0) begin
                        state_nx = ST_AGGR;
                        load_val = bus.aggr_cycles - CNT_W'(1);
                    end else begin
                        state_nx = ST_HOLD;
                        load_val = HOLD_LOAD;
                    end
                end
            end
            ST_L2: if (bus.abort) begin
                state_nx = ST_IDLE;
            end else if (tc) begin
                load = 1'b1;
                if (aggr_en_q && aggr_q != '0) begin
                    state_nx = ST_AGGR;
                    load_val = aggr_q - CNT_W'(1);
                end else begin
                    state_nx = ST_HOLD;
                    load_val = HOLD_LOAD;
                end
            end
            ST_AGGR: if (bus.abort) begin
                state_nx = ST_IDLE;
            end else if (tc) begin
                state_nx = ST_HOLD;
                load     = 1'b1;
                load_val = HOLD_LOAD;
            end
            ST_HOLD: if (bus.abort) begin
                state_nx = ST_IDLE;
            end else if (tc) begin
                state_nx = ST_IDLE;
                capture  = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // state, latched config/mode, result capture and one-cycle pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            aggr_en_q  <= 1'b0;
            aggr_q     <= '0;
            use_int_q  <= 1'b0;
            rounding_q <= '0;
            tininess_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rv_q       <= 1'b0;
            result_q   <= '0;
        end else begin
            state  <= state_nx;
            done_q <= capture;
            err_q  <= illegal;
            if (accept) begin
                aggr_en_q  <= bus.op[OP_AGGR];
                aggr_q     <= bus.aggr_cycles;
                use_int_q  <= bus.use_int_in;
                rounding_q <= bus.rounding_in;
                tininess_q <= bus.tininess_in;
                rv_q       <= 1'b0;
            end
            if (capture) begin
                result_q <= bus.pe_out;
                rv_q     <= 1'b1;
            end
        end
    end

    // select / addsub decode; HOLD parks the array exactly like IDLE
    always_comb begin
        logic [1:0] front, back, outs, asop;
        front = SEL_HOLD;
        back  = SEL_HOLD;
        outs  = SEL_ACC;
        asop  = ADDSUB_ADD;
        case (state)
            ST_L2:   begin front = SEL_MUL; back = SEL_ZERO; outs = SEL_MUL;  asop = ADDSUB_SUB; end
            ST_AGGR: begin front = SEL_MUL; back = SEL_ACC;  outs = SEL_ZERO; asop = ADDSUB_ADD; end
            default: ;
        endcase
        bus.m_sel = '0;
        for (int k = 0; k < NUM_IP; k++)
            bus.m_sel[2*k +: 2] = (k < NUM_IP/2) ? front : back;
        bus.m_sel[2*NUM_IP     +: 2] = outs;
        bus.m_sel[2*NUM_IP + 2 +: 2] = outs;
        bus.addsub_op = {NUM_ADDSUB{asop}};
    end

    assign bus.use_int      = use_int_q;
    assign bus.rounding     = rounding_q;
    assign bus.tininess     = tininess_q;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_pe_op_sequencer.sv
// Directed bench for pe_op_sequencer (NUM_IP=8, NUM_ADDSUB=2, SETTLE=1).
module tb_pe_op_sequencer;
    localparam logic [19:0] SEL_IDLE_V = 20'hAFFFF;
    localparam logic [19:0] SEL_L2_V   = 20'h50055;
    localparam logic [19:0] SEL_AGGR_V = 20'h0AA55;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pe_op_sequencer_if #(.NUM_IP(8), .NUM_ADDSUB(2), .CNT_W(8)) bus ();

    pe_op_sequencer #(.NUM_IP(8), .NUM_ADDSUB(2), .CNT_W(8), .SETTLE(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lat, l2c, agc, hc, bad_mode, rv_seen, done_seen;
    logic [19:0] first_sel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start, then walk the operation cycle by cycle, tallying which
    // encoding was on the bus. start_at/abort_at inject a second start or an
    // abort at sample k (k=1 is the first cycle after the accept edge).
    task automatic run(input logic [1:0] op, input logic [7:0] l2, input logic [7:0] aggr,
                       input logic ui, input logic [2:0] rnd, input logic [31:0] pe,
                       input int start_at, input int abort_at);
        int k;
        bus.op = op; bus.l2_cycles = l2; bus.aggr_cycles = aggr;
        bus.use_int_in = ui; bus.rounding_in = rnd; bus.pe_out = pe;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        l2c = 0; agc = 0; hc = 0; bad_mode = 0; rv_seen = 0; done_seen = 0;
        first_sel = bus.m_sel;
        k = 1;
        while (bus.busy && k <= 1000) begin
            if (bus.m_sel == SEL_L2_V && bus.addsub_op == 4'h5)        l2c++;
            else if (bus.m_sel == SEL_AGGR_V && bus.addsub_op == 4'h0) agc++;
            else if (bus.m_sel == SEL_IDLE_V && bus.addsub_op == 4'h0) hc++;
            if (bus.rounding !== rnd || bus.use_int !== ui) bad_mode++;
            if (bus.result_valid) rv_seen++;
            if (bus.done) done_seen++;
            bus.start = (k == start_at);
            bus.abort = (k == abort_at);
            if (k == start_at) begin
                bus.op = 2'b01; bus.l2_cycles = 8'd3; bus.rounding_in = ~rnd; bus.use_int_in = ~ui;
            end
            tick();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            k++;
        end
        chk("run_bound", 32'(k <= 1000), 32'd1);
        lat = k - 1;
    endtask

    initial begin
        bus.start = 0; bus.op = 0; bus.use_int_in = 0; bus.rounding_in = 0;
        bus.tininess_in = 1; bus.l2_cycles = 0; bus.aggr_cycles = 0;
        bus.abort = 0; bus.pe_out = 0;
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_msel", 32'(bus.m_sel), 32'(SEL_IDLE_V));
        chk("rst_addsub", 32'(bus.addsub_op), 0);
        chk("rst_flags", {28'd0, bus.done, bus.err, bus.result_valid, bus.use_int}, 0);
        chk("rst_mode", {28'd0, bus.rounding, bus.tininess}, 0);
        chk("rst_result", bus.result, 0);
        reset = 1'b1;
        tick();

        // INT L2+AGGR
        run(2'b11, 8'd21, 8'd38, 1'b1, 3'b111, 32'h0000_4100, -1, -1);
        chk("int_lat", 32'(lat), 60);
        chk("int_l2", 32'(l2c), 21);
        chk("int_aggr", 32'(agc), 38);
        chk("int_hold", 32'(hc), 1);
        chk("int_done", 32'(bus.done), 1);
        chk("int_result", bus.result, 32'h0000_4100);
        chk("int_rv", 32'(bus.result_valid), 1);
        chk("int_mode_const", 32'(bad_mode), 0);
        chk("int_tininess", 32'(bus.tininess), 1);
        tick();
        chk("int_done_pulse", 32'(bus.done), 0);
        chk("int_rv_sticky", 32'(bus.result_valid), 1);

        // FP same lengths; result_valid must drop on accept
        run(2'b11, 8'd21, 8'd38, 1'b0, 3'b100, 32'h4682_0000, -1, -1);
        chk("fp_lat", 32'(lat), 60);
        chk("fp_result", bus.result, 32'h4682_0000);
        chk("fp_rounding", 32'(bus.rounding), 32'h4);
        chk("fp_mode_const", 32'(bad_mode), 0);
        chk("fp_rv_cleared", 32'(rv_seen), 0);

        // Skips
        run(2'b01, 8'd5, 8'd7, 1'b0, 3'b000, 32'h1, -1, -1);
        chk("l2only_lat", 32'(lat), 6);
        chk("l2only_aggr", 32'(agc), 0);
        chk("l2only_l2", 32'(l2c), 5);
        run(2'b11, 8'd0, 8'd3, 1'b0, 3'b000, 32'h2, -1, -1);
        chk("l2zero_first", 32'(first_sel), 32'(SEL_AGGR_V));
        chk("l2zero_lat", 32'(lat), 4);
        run(2'b10, 8'd9, 8'd0, 1'b0, 3'b000, 32'h3, -1, -1);
        chk("aggrzero_lat", 32'(lat), 1);
        chk("aggrzero_hold", 32'(hc), 1);
        chk("aggrzero_result", bus.result, 32'h3);

        // Illegal op
        bus.op = 2'b00; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("illegal_err", 32'(bus.err), 1);
        chk("illegal_busy", 32'(bus.busy), 0);
        tick();
        chk("illegal_err_pulse", 32'(bus.err), 0);

        // Second start (with changed config) during L2 is ignored
        run(2'b11, 8'd4, 8'd2, 1'b1, 3'b011, 32'h0000_1234, 2, -1);
        chk("ovl_lat", 32'(lat), 7);
        chk("ovl_done", 32'(bus.done), 1);
        chk("ovl_done_early", 32'(done_seen), 0);
        chk("ovl_mode_const", 32'(bad_mode), 0);
        chk("ovl_err", 32'(bus.err), 0);
        tick();
        chk("ovl_done_once", 32'(bus.done), 0);
        chk("ovl_no_rerun", 32'(bus.busy), 0);

        // Abort at L2 cycle 10
        run(2'b11, 8'd21, 8'd38, 1'b1, 3'b010, 32'hDEAD_BEEF, -1, 10);
        chk("abort_lat", 32'(lat), 10);
        chk("abort_l2", 32'(l2c), 10);
        chk("abort_msel", 32'(bus.m_sel), 32'(SEL_IDLE_V));
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_rv", 32'(bus.result_valid), 0);
        chk("abort_result", bus.result, 32'h0000_1234);
        tick();
        chk("abort_done_late", 32'(bus.done), 0);

        // Abort together with start in IDLE
        bus.op = 2'b11; bus.l2_cycles = 8'd3; bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abstart_busy", 32'(bus.busy), 0);
        chk("abstart_err", 32'(bus.err), 0);

        // Async reset while in AGGR
        bus.op = 2'b11; bus.l2_cycles = 8'd2; bus.aggr_cycles = 8'd4;
        bus.use_int_in = 1'b1; bus.rounding_in = 3'b101; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("rstmid_in_aggr", 32'(bus.m_sel), 32'(SEL_AGGR_V));
        reset = 1'b0;
        #1;
        chk("rstmid_busy", 32'(bus.busy), 0);
        chk("rstmid_msel", 32'(bus.m_sel), 32'(SEL_IDLE_V));
        chk("rstmid_mode", {27'd0, bus.use_int, bus.rounding, bus.tininess}, 0);
        chk("rstmid_result", bus.result, 0);
        chk("rstmid_rv", 32'(bus.result_valid), 0);
        tick();
        reset = 1'b1;
        tick();
        run(2'b11, 8'd2, 8'd2, 1'b0, 3'b001, 32'h0000_0055, -1, -1);
        chk("post_rst_lat", 32'(lat), 5);
        chk("post_rst_result", bus.result, 32'h0000_0055);
        chk("post_rst_rv", 32'(bus.result_valid), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
